// File: rtl/mac_tx_stream.sv
// MAC transmit serializer: byte stream -> FIFO -> optional preamble/SFD -> LSB-first RMII/MII symbols, then inter-frame gap.
// Latency: symbol reaches eth_txd one clk after the transmit_clk sample goes high; a frame starts on the tick after its start condition.
// Backpressure: s_ready = FIFO not full; bytes are only popped on transmit_clk ticks, so between ticks the FIFO only fills.
//
// Ports: clk/rst (async, active-low), transmit_clk (PHY reference, sampled in clk),
//        s_data/s_last/s_valid/s_ready (input byte stream), eth_txd/eth_txen (PHY pins),
//        busy (FSM not idle), underrun (sticky starvation flag).
module mac_tx_stream #(
    parameter int TXD_WIDTH       = 2,
    parameter int FIFO_DEPTH      = 16,
    parameter int START_LEVEL     = 8,
    parameter int INSERT_PREAMBLE = 1,
    parameter int IPG_BYTES       = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 transmit_clk,
    input  logic [7:0]           s_data,
    input  logic                 s_last,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [TXD_WIDTH-1:0] eth_txd,
    output logic                 eth_txen,
    output logic                 busy,
    output logic                 underrun
);
    localparam int SYMS      = 8 / TXD_WIDTH;
    localparam int SW        = $clog2(SYMS);
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int CW        = $clog2(FIFO_DEPTH + 1);
    localparam int IPG_TICKS = IPG_BYTES * SYMS;
    localparam int IW        = (IPG_TICKS > 1) ? $clog2(IPG_TICKS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_PREAMBLE, ST_DATA, ST_DISCARD, ST_IPG
    } state_t;

    state_t state, state_nxt;

    // ---------------- transmit_clk edge detect ----------------
    logic tclk_s, tclk_p, tick;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tclk_s <= 1'b0;
            tclk_p <= 1'b0;
        end else begin
            tclk_s <= transmit_clk;
            tclk_p <= tclk_s;
        end
    end
    assign tick = tclk_s & ~tclk_p;

    // ---------------- byte FIFO (data + last) ----------------
    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, frames_queued;
    logic          wr_en, pop, empty, full;
    logic [8:0]    head;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign s_ready = ~full;
    assign wr_en   = s_valid & s_ready;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {s_last, s_data};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            frames_queued <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            case ({wr_en & s_last, pop & head[8]})
                2'b10:   frames_queued <= frames_queued + CW'(1);
                2'b01:   frames_queued <= frames_queued - CW'(1);
                default: frames_queued <= frames_queued;
            endcase
        end
    end

    // ---------------- serializer FSM ----------------
    logic [SW-1:0]        sym_cnt;
    logic [2:0]           byte_cnt;
    logic [IW-1:0]        ipg_cnt;
    logic [7:0]           sh_q;
    logic                 last_q;
    logic                 start, sym_first, sym_last, starved;
    logic [7:0]           pre_byte;
    int                   sym_base;
    logic [TXD_WIDTH-1:0] txd_nxt;
    logic                 txen_nxt;

    assign start     = (count >= CW'(START_LEVEL)) || (frames_queued != '0);
    assign sym_first = (sym_cnt == '0);
    assign sym_last  = (sym_cnt == SW'(SYMS - 1));
    assign starved   = (state == ST_DATA) && sym_first && empty;
    assign pre_byte  = (byte_cnt == 3'd7) ? 8'hD5 : 8'h55;
    assign sym_base  = int'(sym_cnt) * TXD_WIDTH;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (tick) begin
            case (state)
                ST_IDLE:     if (start) state_nxt = (INSERT_PREAMBLE != 0) ? ST_PREAMBLE : ST_DATA;
                ST_PREAMBLE: if (sym_last && byte_cnt == 3'd7) state_nxt = ST_DATA;
                ST_DATA: begin
                    if (starved)                state_nxt = ST_DISCARD;
                    else if (sym_last && last_q) state_nxt = ST_IPG;
                end
                ST_DISCARD:  if (!empty && head[8]) state_nxt = ST_IPG;
                ST_IPG:      if (ipg_cnt == IW'(IPG_TICKS - 1)) state_nxt = ST_IDLE;
                default:     state_nxt = ST_IDLE;
            endcase
        end
    end

    // Values the pins take on this tick, plus the FIFO pop strobe.
    always_comb begin
        pop      = 1'b0;
        txd_nxt  = '0;
        txen_nxt = 1'b0;
        case (state)
            ST_PREAMBLE: begin
                txd_nxt  = pre_byte[sym_base +: TXD_WIDTH];
                txen_nxt = 1'b1;
            end
            ST_DATA: begin
                if (sym_first) begin
                    // A starved byte leaves txen low from this tick on.
                    if (!empty) begin
                        pop      = tick;
                        txd_nxt  = head[TXD_WIDTH-1:0];
                        txen_nxt = 1'b1;
                    end
                end else begin
                    txd_nxt  = sh_q[sym_base +: TXD_WIDTH];
                    txen_nxt = 1'b1;
                end
            end
            ST_DISCARD: pop = tick & ~empty;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sym_cnt  <= '0;
            byte_cnt <= '0;
            ipg_cnt  <= '0;
            sh_q     <= '0;
            last_q   <= 1'b0;
            eth_txd  <= '0;
            eth_txen <= 1'b0;
            underrun <= 1'b0;
        end else if (tick) begin
            eth_txd  <= txd_nxt;
            eth_txen <= txen_nxt;
            if (starved) underrun <= 1'b1;
            ipg_cnt  <= (state == ST_IPG) ? ipg_cnt + IW'(1) : '0;
            case (state)
                ST_PREAMBLE: begin
                    sym_cnt <= sym_cnt + SW'(1);
                    if (sym_last) byte_cnt <= byte_cnt + 3'd1;
                end
                ST_DATA: begin
                    sym_cnt <= sym_cnt + SW'(1);
                    if (pop) begin
                        sh_q   <= head[7:0];
                        last_q <= head[8];
                    end
                end
                default: begin
                    sym_cnt  <= '0;
                    byte_cnt <= '0;
                end
            endcase
        end
    end
endmodule
